// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : Instruction handshake, register-file, ALU and write-back bundle.
// Revision : 1.0
// ============================================================================
interface alu_issue_ctrl_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [4:0]  rs_addr_o;
  logic [4:0]  rt_addr_o;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        branch_taken_o;
  logic        illegal_o;
  logic        busy_o;

  modport slave (
    input  instr_valid_i, instr_i, rs_data_i, rt_data_i, alu_result_i, alu_zero_i,
    output instr_ready_o, rs_addr_o, rt_addr_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           wb_en_o, wb_addr_o, wb_data_o, branch_taken_o, illegal_o, busy_o
  );

  modport master (
    output instr_valid_i, instr_i, rs_data_i, rt_data_i, alu_result_i, alu_zero_i,
    input  instr_ready_o, rs_addr_o, rt_addr_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           wb_en_o, wb_addr_o, wb_data_o, branch_taken_o, illegal_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Four-state MIPS ALU issue controller (IDLE/DECODE/EXEC/WB).
// Revision : 1.0
// ============================================================================
module alu_issue_ctrl (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_issue_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q;
  logic [3:0]  ctrl_q;
  logic [31:0] src1_q, src2_q;
  logic [4:0]  dest_q;
  logic        wr_q, beq_q, bne_q, ill_q;
  logic [31:0] result_q;
  logic        zero_q;

  logic        accept;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_src1, dec_src2;
  logic [4:0]  dec_dest;
  logic        dec_wr, dec_beq, dec_bne, dec_ill;
  logic [31:0] imm_sext, imm_zext;

  logic        instr_ready, busy, wb_en, br_taken, illegal;

  assign accept   = (state_q == S_IDLE) && bus.instr_valid_i;
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {16'h0000, instr_q[15:0]};

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, all derived from registered state so reset clears them at once
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    wb_en       = 1'b0;
    br_taken    = 1'b0;
    illegal     = 1'b0;
    if (state_q == S_WB) begin
      wb_en    = wr_q;
      br_taken = (beq_q && zero_q) || (bne_q && !zero_q);
      illegal  = ill_q;
    end
  end

  always_comb begin
    dec_ctrl = 4'b0000;
    dec_src1 = bus.rs_data_i;
    dec_src2 = bus.rt_data_i;
    dec_dest = instr_q[15:11];
    dec_wr   = 1'b0;
    dec_beq  = 1'b0;
    dec_bne  = 1'b0;
    dec_ill  = 1'b0;
    case (instr_q[31:26])
      OP_RTYPE: begin
        dec_wr = 1'b1;
        case (instr_q[5:0])
          6'h20: dec_ctrl = 4'b0000;
          6'h22: dec_ctrl = 4'b0001;
          6'h24: dec_ctrl = 4'b0010;
          6'h25: dec_ctrl = 4'b0011;
          6'h2A: dec_ctrl = 4'b0100;
          6'h06: dec_ctrl = 4'b0101;
          6'h02: begin
            dec_ctrl = 4'b1000;
            dec_src1 = {27'd0, instr_q[10:6]};
          end
          default: begin
            dec_wr  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_ctrl = 4'b0000;
        dec_src2 = imm_sext;
        dec_dest = instr_q[20:16];
        dec_wr   = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl = 4'b0100;
        dec_src2 = imm_sext;
        dec_dest = instr_q[20:16];
        dec_wr   = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl = 4'b0110;
        dec_src2 = imm_zext;
        dec_dest = instr_q[20:16];
        dec_wr   = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl = 4'b0001;
        dec_beq  = 1'b1;
      end
      OP_BNE: begin
        dec_ctrl = 4'b0001;
        dec_bne  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Datapath registers; operand/control registers only move at the end of
  // DECODE so the ALU inputs stay steady through EXEC and afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_q  <= 32'd0;
      ctrl_q   <= 4'b0000;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      dest_q   <= 5'd0;
      wr_q     <= 1'b0;
      beq_q    <= 1'b0;
      bne_q    <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= bus.instr_i;
      end
      if (state_q == S_DECODE) begin
        ctrl_q <= dec_ctrl;
        src1_q <= dec_src1;
        src2_q <= dec_src2;
        dest_q <= dec_dest;
        wr_q   <= dec_wr && (dec_dest != 5'd0);
        beq_q  <= dec_beq;
        bne_q  <= dec_bne;
        ill_q  <= dec_ill;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_result_i;
        zero_q   <= bus.alu_zero_i;
      end
    end
  end

  assign bus.instr_ready_o  = instr_ready;
  assign bus.busy_o         = busy;
  assign bus.wb_en_o        = wb_en;
  assign bus.branch_taken_o = br_taken;
  assign bus.illegal_o      = illegal;
  assign bus.rs_addr_o      = instr_q[25:21];
  assign bus.rt_addr_o      = instr_q[20:16];
  assign bus.alu_ctrl_o     = ctrl_q;
  assign bus.alu_src1_o     = src1_q;
  assign bus.alu_src2_o     = src2_q;
  assign bus.wb_addr_o      = dest_q;
  assign bus.wb_data_o      = result_q;

endmodule
`default_nettype wire
